muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, which sets the operand width and the width of each result register (minimum 4, even).
REQ-002 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  in  1  request a new operation; sampled only in IDLE.
REQ-005 op  in  2  operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 a  in  WIDTH  operand A (multiplicand or dividend).
REQ-007 b  in  WIDTH  operand B (multiplier or divisor).
REQ-008 wr_hi  in  1  direct write of hi from wdata (mthi).
REQ-009 wr_lo  in  1  direct write of lo from wdata (mtlo).
REQ-010 wdata  in  WIDTH  data for direct writes.
REQ-011 busy  out  1  high while an operation is in progress.
REQ-012 done  out  1  one-cycle pulse when a result has been committed to hi/lo.
REQ-013 divzero  out  1  one-cycle pulse, coincident with done, when a DIV/DIVU had b = 0.
REQ-014 hi  out  WIDTH  upper product half, or remainder.
REQ-015 lo  out  WIDTH  lower product half, or quotient.

Function
REQ-016 The state machine SHALL have three states: IDLE, CALC and FIX.
REQ-017 In IDLE with start=1, the block SHALL latch op, |a| and |b| (absolute values for signed ops), and the result signs, load an iteration counter with WIDTH, and go to CALC.
REQ-018 CALC SHALL perform one step per cycle for exactly WIDTH cycles: shift-add for multiply, restoring subtract-shift for divide. After the last step it SHALL go to FIX.
REQ-019 FIX SHALL apply sign correction and write hi/lo in one cycle, then return to IDLE.
REQ-020 On that same edge, FIX SHALL raise done (and divzero if applicable) for exactly one cycle.
REQ-021 Latency: if start is sampled at edge 0, busy SHALL be high from edge 0 until edge WIDTH+2. At edge WIDTH+2, busy SHALL fall and done SHALL rise; for WIDTH=32 this is edge 34.
REQ-022 hi and lo SHALL hold their previous values throughout CALC and FIX until the commit edge. Internal partial results SHALL NOT be visible on hi/lo.
REQ-023 MULT/MULTU results:
- {hi,lo} SHALL equal the full 2*WIDTH-bit product.
- For MULT the product is two's-complement signed.
REQ-024 DIVU results: lo = a/b and hi = a mod b, both unsigned.
REQ-025 DIV results:
- The quotient SHALL truncate toward zero.
- The remainder SHALL take the sign of a.
- The most-negative value divided by -1 SHALL give lo = most-negative value and hi = 0, with no flag.
REQ-026 Divide by zero (DIV or DIVU with b=0) SHALL run the normal latency and commit lo = all ones and hi = a unmodified, with divzero pulsed.
REQ-027 start while busy=1 SHALL be ignored; no queuing.
REQ-028 wr_hi/wr_lo while busy=1 SHALL be ignored.
REQ-029 wr_hi/wr_lo in IDLE SHALL update hi/lo at that edge.
REQ-030 wr_hi/wr_lo together with start in IDLE: the writes SHALL take effect, start SHALL be accepted, and the later commit SHALL overwrite hi/lo.
REQ-031 Operand inputs SHALL be sampled only on the start edge; later changes SHALL have no effect.

Reset
REQ-032 On reset=1 at a clock edge, the block SHALL go to IDLE and clear busy, done, divzero, hi, lo and the counter to 0, regardless of state.
REQ-033 Reset mid-operation SHALL discard the operation; no done pulse SHALL follow.
REQ-034 Reset SHALL take priority over start, wr_hi and wr_lo in the same cycle.

Verification
REQ-035 Run MULT with WIDTH=32, a=0xFFFFFFFE (-2), b=0x00000003. Required: done at edge 34 after start, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-036 Run MULTU and then DIVU back to back:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF gives hi=0xFFFFFFFE, lo=0x00000001.
- DIVU a=100, b=7 gives lo=14, hi=2.
REQ-037 Run DIV with a=-7, b=2. Required: lo=-3 (0xFFFFFFFD), hi=-1 (0xFFFFFFFF).
REQ-038 Run DIV with a=0x80000000, b=-1. Required: lo=0x80000000, hi=0, divzero=0.
REQ-039 Run DIVU with a=0x1234, b=0. Required: lo=0xFFFFFFFF, hi=0x1234, divzero and done pulse together for one cycle.
REQ-040 Control-path checks:
- start and wr_lo during CALC are ignored, and the result is unchanged.
- Reset at CALC cycle 10 gives busy=0, hi=lo=0 and no done pulse.
- A following start then completes normally.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with hi/lo result registers.
// One radix-2 step per cycle (shift-add multiply, restoring divide) on
// magnitudes; signs are re-applied in a single fix-up cycle before commit.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam int CW = $clog2(WIDTH + 1);

  // Two's-complement negate when en is set (magnitude extraction / sign fix-up).
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  logic [1:0]         state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   opb;
  logic               is_div;
  logic               neg_lo;
  logic               neg_hi;
  logic               dz_r;
  logic               sgn;
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   diff;
  logic               ge;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign sgn  = ~op[0];
  assign a_s  = a;
  assign b_s  = b;
  assign busy = (state != IDLE);

  // One iteration step: acc upper half is the partial product / remainder,
  // lower half is the multiplier being consumed / quotient being built.
  always_comb begin
    acc_next = acc;
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge       = (shifted >= {1'b0, opb});
    diff     = shifted[WIDTH-1:0] - opb;
    if (is_div) begin
      acc_next = {(ge ? diff : shifted[WIDTH-1:0]), acc[WIDTH-2:0], ge};
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Sign correction of the magnitude result, committed in FIX.
  always_comb begin
    prod   = cond_neg2(acc, neg_lo);
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div) begin
      res_lo = cond_neg(acc[WIDTH-1:0], neg_lo);
      res_hi = cond_neg(acc[2*WIDTH-1:WIDTH], neg_hi);
    end
  end

  // Control: state machine, iteration counter, visible hi/lo and pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      divzero <= 1'b0;
    end else begin
      done    <= 1'b0;
      divzero <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_hi) hi <= wdata;
          if (wr_lo) lo <= wdata;
          if (start) begin
            state <= CALC;
            count <= CW'(WIDTH);
          end
        end
        CALC: begin
          if (count != '0) count <= count - CW'(1);
          else             state <= FIX;
        end
        FIX: begin
          state   <= IDLE;
          hi      <= res_hi;
          lo      <= res_lo;
          done    <= 1'b1;
          divzero <= dz_r;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: latch magnitudes and result signs on start, then iterate.
  // A divide by zero keeps the raw dividend so the remainder comes out as a.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      is_div <= op[1];
      opb    <= cond_neg(b, sgn & b_s[WIDTH-1]);
      if (op[1] && (b == '0)) begin
        acc    <= {{WIDTH{1'b0}}, a};
        neg_lo <= 1'b0;
        neg_hi <= 1'b0;
        dz_r   <= 1'b1;
      end else begin
        acc    <= {{WIDTH{1'b0}}, cond_neg(a, sgn & a_s[WIDTH-1])};
        neg_lo <= sgn & (a_s[WIDTH-1] ^ b_s[WIDTH-1]);
        neg_hi <= op[1] ? (sgn & a_s[WIDTH-1]) : (sgn & (a_s[WIDTH-1] ^ b_s[WIDTH-1]));
        dz_r   <= 1'b0;
      end
    end else if (state == CALC && count != '0) begin
      acc <= acc_next;
    end
  end

endmodule
